// File: rtl/dvp_frame_tx.sv
// DVP (OV7670-style) pixel bus transmitter: emits RGB565 test frames on pclk/vsync/href/d,
// two bytes per pixel, high byte first, with colour-bar or coordinate-ramp content.
module dvp_frame_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 288,
    parameter int V_ACTIVE = 480,
    parameter int VS_LINES = 3,
    parameter int VBP      = 17,
    parameter int VFP      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pat_sel,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] d,
    output logic       frame_done
);
    localparam int LT      = 2 * H_ACTIVE + H_BLANK;
    localparam int FL      = VS_LINES + VBP + V_ACTIVE + VFP;
    localparam int HW      = $clog2(LT);
    localparam int VW      = $clog2(FL);
    localparam int V_FIRST = VS_LINES + VBP;
    localparam int V_END   = V_FIRST + V_ACTIVE;
    localparam int BAR_W   = H_ACTIVE / 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic          pat, pat_n;
    logic          tick;

    // A tick is the clk edge where pclk falls, so outputs settle half a pclk before its rise.
    assign tick = pclk;

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        vcnt_n  = vcnt;
        pat_n   = pat;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = RUN;
                    hcnt_n  = '0;
                    vcnt_n  = '0;
                    pat_n   = pat_sel;
                end
            end
            RUN: begin
                if (32'(hcnt) == LT - 1) begin
                    hcnt_n = '0;
                    if (32'(vcnt) == FL - 1) begin
                        vcnt_n = '0;
                        if (en) pat_n = pat_sel;
                        else    state_n = IDLE;
                    end else begin
                        vcnt_n = vcnt + VW'(1);
                    end
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the post-tick counters so they register on the same tick.
    logic        run_n, vs_n, act_n, done_n;
    logic [7:0]  x8, y8, d_n;
    logic [2:0]  bar;
    logic [15:0] pix;

    always_comb begin
        run_n  = (state_n == RUN);
        vs_n   = run_n && (32'(vcnt_n) < VS_LINES);
        act_n  = run_n && (32'(vcnt_n) >= V_FIRST) && (32'(vcnt_n) < V_END)
                 && (32'(hcnt_n) < 2 * H_ACTIVE);
        done_n = run_n && (32'(hcnt_n) == LT - 1) && (32'(vcnt_n) == FL - 1);
        x8     = 8'(hcnt_n >> 1);
        y8     = 8'(32'(vcnt_n) - V_FIRST);
        bar    = 3'(32'(hcnt_n >> 1) / BAR_W);
        pix    = 16'h0000;
        if (pat_n) begin
            pix = {x8, y8};
        end else begin
            case (bar)
                3'd0: pix = 16'hFFFF;
                3'd1: pix = 16'hFFE0;
                3'd2: pix = 16'h07FF;
                3'd3: pix = 16'h07E0;
                3'd4: pix = 16'hF81F;
                3'd5: pix = 16'hF800;
                3'd6: pix = 16'h001F;
                default: pix = 16'h0000;
            endcase
        end
        d_n = act_n ? (hcnt_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            vcnt       <= '0;
            pat        <= 1'b0;
            pclk       <= 1'b0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            pclk       <= ~pclk;
            frame_done <= 1'b0;
            if (tick) begin
                state      <= state_n;
                hcnt       <= hcnt_n;
                vcnt       <= vcnt_n;
                pat        <= pat_n;
                vsync      <= vs_n;
                href       <= act_n;
                d          <= d_n;
                frame_done <= done_n;
            end
        end
    end
endmodule
